// File: rtl/calc_input_sequencer.sv
// Collects three button-entered operands (a, b, op) and presents them as one atomic calc_word.
// Optional load_btn debounce filter is enabled by defining CALC_SEQ_DEBOUNCE_EN.
module calc_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       load_btn,
  input  logic       clr,
  output logic [7:0] calc_word,
  output logic       word_valid,
  output logic [1:0] state,
  output logic       err
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } seq_state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  seq_state_t cur;
  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_d;
  logic       evt;
  logic       valid_ab;
  logic       valid_op;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic [1:0] op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= load_btn;
      sync2 <= sync1;
    end
  end

`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] db_cnt;

  // Level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      level  <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign evt      = level & ~level_d;
  assign valid_ab = (din[7:3] == 5'd0);
  assign valid_op = (din[7:2] == 6'd0);

  // calc_word is written only on the WAIT_OP -> READY step so downstream never sees a partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      calc_word  <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        cur        <= WAIT_A;
        a_q        <= '0;
        b_q        <= '0;
        op_q       <= '0;
        calc_word  <= '0;
        word_valid <= 1'b0;
      end else if (evt) begin
        case (cur)
          WAIT_A: begin
            if (valid_ab) begin
              a_q <= din[2:0];
              cur <= WAIT_B;
            end else begin
              err <= 1'b1;
            end
          end
          WAIT_B: begin
            if (valid_ab) begin
              b_q <= din[2:0];
              cur <= WAIT_OP;
            end else begin
              err <= 1'b1;
            end
          end
          WAIT_OP: begin
            if (valid_op) begin
              op_q       <= din[1:0];
              calc_word  <= {din[1:0], b_q, a_q};
              word_valid <= 1'b1;
              cur        <= READY;
            end else begin
              err <= 1'b1;
            end
          end
          READY: begin
            if (valid_ab) begin
              a_q        <= din[2:0];
              word_valid <= 1'b0;
              cur        <= WAIT_B;
            end else begin
              err <= 1'b1;
            end
          end
          default: cur <= WAIT_A;
        endcase
      end
    end
  end

  assign state = cur;

  a_valid_tracks_ready: assert property (@(posedge clk) disable iff (rst)
    word_valid == (cur == READY));

  a_evt_single_cycle: assert property (@(posedge clk) disable iff (rst)
    evt |=> !evt);

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Randomized bench for calc_input_sequencer with an operand-count reference model.
module tb_calc_input_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       load_btn = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] calc_word;
  logic       word_valid;
  logic [1:0] state;
  logic       err;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_btn   (load_btn),
    .clr        (clr),
    .calc_word  (calc_word),
    .word_valid (word_valid),
    .state      (state),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int d;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  errs  = 0;
  int  cyc   = 0;
  bit  model_on = 1'b0;

  // Model: number of operands collected so far (3 = complete word shown).
  int  stage = 0;
  int  ma = 0, mb = 0, mop = 0, mword = 0;
  bit  merr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stage = 0; ma = 0; mb = 0; mop = 0; mword = 0; merr = 1'b0;
      q.delete();
    end else begin
      ev_t e;
      bit  due;
      cyc++;
      merr = 1'b0;
      due  = 1'b0;
      if (q.size() > 0 && q[0].at == cyc) begin
        e   = q.pop_front();
        due = 1'b1;
      end
      if (clr) begin
        stage = 0; ma = 0; mb = 0; mop = 0; mword = 0;
      end else if (due) begin
        if (stage == 0 || stage == 3) begin
          if (e.d < 8) begin ma = e.d; stage = 1; end else merr = 1'b1;
        end else if (stage == 1) begin
          if (e.d < 8) begin mb = e.d; stage = 2; end else merr = 1'b1;
        end else begin
          if (e.d < 4) begin
            mop = e.d; mword = mop * 64 + mb * 8 + ma; stage = 3;
          end else merr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("state", 32'(state), 32'(stage));
      chk("calc_word", 32'(calc_word), 32'(mword));
      chk("word_valid", 32'(word_valid), 32'(stage == 3));
      chk("err", 32'(err), 32'(merr));
    end
  end

  always @(negedge clk) if (err === 1'b1) errs++;

  // Starts and ends at posedge+1; the press is acted on at the 3rd edge after it rises.
  task automatic press(input logic [7:0] d, input int hi, input int lo, input int clr_at, input bit rclr);
    ev_t e;
    din = d;
    load_btn = 1'b1;
    e.at = cyc + 3;
    e.d  = int'(d);
    q.push_back(e);
    for (int i = 0; i < hi + lo; i++) begin
      clr = (i == clr_at) || (rclr && $urandom_range(0, 19) == 0);
      @(posedge clk); #1;
      if (i == hi - 1) load_btn = 1'b0;
    end
    clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int e0, hi, lo;
    logic [7:0] d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_word", 32'(calc_word), 32'h00);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef CALC_SEQ_DEBOUNCE_EN
    e0 = errs;
    press(8'h01, 10, 30, -1, 1'b0);
    chk("db_short_state", 32'(state), 32'd0);
    press(8'h01, 20, 40, -1, 1'b0);
    chk("db_long_state", 32'(state), 32'd1);
    press(8'h02, 20, 40, -1, 1'b0);
    chk("db_second_state", 32'(state), 32'd2);
    chk("db_word_held", 32'(calc_word), 32'h00);
    chk("db_no_err", 32'(errs - e0), 32'd0);
`else
    model_on = 1'b1;
    e0 = errs;
    press(8'h05, 1, 4, -1, 1'b0);
    press(8'h03, 2, 3, -1, 1'b0);
    press(8'h02, 3, 2, -1, 1'b0);
    chk("seq_word", 32'(calc_word), 32'h9D);
    chk("seq_valid", 32'(word_valid), 32'd1);
    chk("seq_state", 32'(state), 32'd3);
    chk("seq_no_err", 32'(errs - e0), 32'd0);

    press(8'h07, 1, 4, -1, 1'b0);
    chk("rdy_state", 32'(state), 32'd1);
    chk("rdy_valid", 32'(word_valid), 32'd0);
    chk("rdy_word_held", 32'(calc_word), 32'h9D);
    press(8'h00, 1, 4, -1, 1'b0);
    press(8'h01, 8, 2, -1, 1'b0);
    chk("rdy_word2", 32'(calc_word), 32'h47);

    press(8'h06, 1, 4, -1, 1'b0);
    chk("pre_rst_state", 32'(state), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_word", 32'(calc_word), 32'h00);
    chk("arst_valid", 32'(word_valid), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    press(8'h04, 1, 4, -1, 1'b0);
    chk("post_rst_state", 32'(state), 32'd1);
    press(8'h00, 1, 4, -1, 1'b0);
    press(8'h00, 1, 4, -1, 1'b0);
    chk("post_rst_word", 32'(calc_word), 32'h04);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_word", 32'(calc_word), 32'h00);

    e0 = errs;
    press(8'h09, 1, 4, -1, 1'b0);
    chk("bad_a_state", 32'(state), 32'd0);
    chk("bad_a_err_cycles", 32'(errs - e0), 32'd1);
    press(8'h01, 1, 4, -1, 1'b0);
    chk("good_a_state", 32'(state), 32'd1);

    press(8'h02, 1, 4, -1, 1'b0);
    chk("wait_op_state", 32'(state), 32'd2);
    press(8'h03, 1, 4, 2, 1'b0);
    chk("clr_evt_state", 32'(state), 32'd0);
    chk("clr_evt_word", 32'(calc_word), 32'h00);
    chk("clr_evt_err", 32'(errs - e0), 32'd1);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 14) == 0) begin
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
      end else begin
        d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
        hi = $urandom_range(1, 6);
        lo = ((hi >= 3) ? 1 : 3 - hi) + $urandom_range(0, 3);
        press(d, hi, lo, -1, 1'b1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
